// File: rtl/three_wire_pkg.sv
// Shared types and constants for the three-wire sensor master.
// Holds the state encoding, default parameter values and sensor command codes.
package three_wire_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_CMD     = 3'd2,
        ST_DATA_WR = 3'd3,
        ST_DATA_RD = 3'd4,
        ST_HOLD    = 3'd5,
        ST_DONE    = 3'd6
    } state_t;

    localparam int DEF_CLK_DIV = 4;
    localparam int DEF_CMD_W   = 8;
    localparam int DEF_DATA_W  = 9;

    localparam logic [7:0] READ_TEMP     = 8'hAA;
    localparam logic [7:0] START_CONVERT = 8'hEE;
    localparam logic [7:0] STOP_CONVERT  = 8'h22;
    localparam logic [7:0] WRITE_CONFIG  = 8'h0C;
    localparam logic [7:0] READ_CONFIG   = 8'hAC;

endpackage

// File: rtl/three_wire_tick.sv
// Half-period tick generator: pulses tick on the last CLK_IN cycle of each
// CLK_DIV-cycle window while enabled; clr restarts the window.
module three_wire_tick
    import three_wire_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic clk,
    input  logic clr_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!clr_n || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

    assign tick = en && (cnt == LAST);

endmodule

// File: rtl/three_wire_master.sv
// Three-wire (CLK/DQ/RST) sensor master: sends a command LSB first, then an
// optional write or read data phase, and reports the read result on DONE.
module three_wire_master
    import three_wire_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV,
    parameter int CMD_W   = DEF_CMD_W,
    parameter int DATA_W  = DEF_DATA_W
) (
    input  logic                        CLK_IN,
    input  logic                        CLR_N,
    input  logic                        START,
    input  logic [CMD_W-1:0]            CMD,
    input  logic [DATA_W-1:0]           WR_DATA,
    input  logic [$clog2(DATA_W+1)-1:0] DATA_LEN,
    input  logic                        DIR,
    input  logic                        DQ_IN,
    output logic                        BUSY,
    output logic                        DONE,
    output logic [DATA_W-1:0]           RD_DATA,
    output logic                        CLK_OUT,
    output logic                        RST,
    output logic                        TRI_EN,
    output logic                        DQ_OUT,
    output logic [2:0]                  dbg_state
);

    localparam int LEN_W = $clog2(DATA_W + 1);
    localparam int MAX_B = (CMD_W > DATA_W) ? CMD_W : DATA_W;
    localparam int CNT_W = $clog2(MAX_B + 1);

    state_t              state, state_d;
    logic [CNT_W-1:0]    bit_cnt, bit_d;
    logic                sclk, sclk_d, dq, dq_d, dir_q, dir_d;
    logic [CMD_W-1:0]    cmd_q, cmd_d;
    logic [DATA_W-1:0]   wr_q, wr_d, rd_sh, rd_sh_d, rd_q, rd_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic                tick, last_cmd, last_data, read_turn;

    three_wire_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk   (CLK_IN),
        .clr_n (CLR_N),
        .en    (state != ST_IDLE),
        .clr   ((state == ST_IDLE) && START),
        .tick  (tick)
    );

    assign last_cmd  = (bit_cnt == CNT_W'(CMD_W - 1));
    assign last_data = ((bit_cnt + CNT_W'(1)) == CNT_W'(len_q));
    assign read_turn = dir_q && (len_q != '0);

    // sclk doubles as the phase flag: low half first, high half second.
    always_comb begin
        state_d = state;
        bit_d   = bit_cnt;
        sclk_d  = sclk;
        dq_d    = dq;
        cmd_d   = cmd_q;
        wr_d    = wr_q;
        len_d   = len_q;
        dir_d   = dir_q;
        rd_sh_d = rd_sh;
        rd_d    = rd_q;
        case (state)
            ST_IDLE: begin
                if (START) begin
                    state_d = ST_SETUP;
                    cmd_d   = CMD;
                    wr_d    = WR_DATA;
                    len_d   = (DATA_LEN > LEN_W'(DATA_W)) ? LEN_W'(DATA_W) : DATA_LEN;
                    dir_d   = DIR;
                    rd_sh_d = '0;
                    bit_d   = '0;
                end
            end
            ST_SETUP: begin
                if (tick) begin
                    state_d = ST_CMD;
                    sclk_d  = 1'b0;
                    dq_d    = cmd_q[0];
                end
            end
            ST_CMD: begin
                if (tick) begin
                    if (!sclk) begin
                        sclk_d = 1'b1;
                    end else if (!last_cmd) begin
                        sclk_d = 1'b0;
                        bit_d  = bit_cnt + 1'b1;
                        cmd_d  = cmd_q >> 1;
                        dq_d   = cmd_q[1];
                    end else if (len_q == '0) begin
                        state_d = ST_HOLD;
                    end else begin
                        sclk_d = 1'b0;
                        bit_d  = '0;
                        if (dir_q) begin
                            state_d = ST_DATA_RD;
                            dq_d    = 1'b0;
                        end else begin
                            state_d = ST_DATA_WR;
                            dq_d    = wr_q[0];
                        end
                    end
                end
            end
            ST_DATA_WR: begin
                if (tick) begin
                    if (!sclk) begin
                        sclk_d = 1'b1;
                    end else if (last_data) begin
                        state_d = ST_HOLD;
                    end else begin
                        sclk_d = 1'b0;
                        bit_d  = bit_cnt + 1'b1;
                        wr_d   = wr_q >> 1;
                        dq_d   = wr_q[1];
                    end
                end
            end
            ST_DATA_RD: begin
                if (tick) begin
                    if (!sclk) begin
                        sclk_d  = 1'b1;
                        rd_sh_d = {DQ_IN, rd_sh[DATA_W-1:1]};
                    end else if (last_data) begin
                        state_d = ST_HOLD;
                    end else begin
                        sclk_d = 1'b0;
                        bit_d  = bit_cnt + 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (tick) begin
                    state_d = ST_DONE;
                    // Bits entered at the top; realign so the first bit lands at bit 0.
                    if (dir_q) rd_d = rd_sh >> (LEN_W'(DATA_W) - len_q);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                dq_d    = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK_IN) begin
        if (!CLR_N) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
            sclk    <= 1'b1;
            dq      <= 1'b0;
            cmd_q   <= '0;
            wr_q    <= '0;
            len_q   <= '0;
            dir_q   <= 1'b0;
            rd_sh   <= '0;
            rd_q    <= '0;
        end else begin
            state   <= state_d;
            bit_cnt <= bit_d;
            sclk    <= sclk_d;
            dq      <= dq_d;
            cmd_q   <= cmd_d;
            wr_q    <= wr_d;
            len_q   <= len_d;
            dir_q   <= dir_d;
            rd_sh   <= rd_sh_d;
            rd_q    <= rd_d;
        end
    end

    assign BUSY      = (state != ST_IDLE);
    assign DONE      = (state == ST_DONE);
    assign RST       = (state != ST_IDLE) && (state != ST_DONE);
    // The line stays driven through HOLD unless a read turned it around.
    assign TRI_EN    = (state == ST_SETUP) || (state == ST_CMD) || (state == ST_DATA_WR) ||
                       ((state == ST_HOLD) && !read_turn);
    assign DQ_OUT    = TRI_EN & dq;
    assign CLK_OUT   = sclk;
    assign RD_DATA   = rd_q;
    assign dbg_state = state;

endmodule

// File: tb/tb_three_wire_master.sv
// Randomized scoreboard bench for three_wire_master with a behavioural sensor
// model; expectations are derived from transaction-level rules.
module tb_three_wire_master;
    import three_wire_pkg::*;

    localparam int CLK_DIV = 2;
    localparam int CMD_W   = 8;
    localparam int DATA_W  = 9;
    localparam int LEN_W   = $clog2(DATA_W + 1);

    logic              CLK_IN = 1'b0;
    logic              CLR_N = 1'b0;
    logic              START = 1'b0;
    logic [CMD_W-1:0]  CMD = '0;
    logic [DATA_W-1:0] WR_DATA = '0;
    logic [LEN_W-1:0]  DATA_LEN = '0;
    logic              DIR = 1'b0;
    logic              DQ_IN = 1'b0;
    logic              BUSY, DONE, CLK_OUT, RST, TRI_EN, DQ_OUT;
    logic [DATA_W-1:0] RD_DATA;
    logic [2:0]        dbg_state;

    three_wire_master #(.CLK_DIV(CLK_DIV), .CMD_W(CMD_W), .DATA_W(DATA_W)) dut (
        .CLK_IN(CLK_IN), .CLR_N(CLR_N), .START(START), .CMD(CMD), .WR_DATA(WR_DATA),
        .DATA_LEN(DATA_LEN), .DIR(DIR), .DQ_IN(DQ_IN), .BUSY(BUSY), .DONE(DONE),
        .RD_DATA(RD_DATA), .CLK_OUT(CLK_OUT), .RST(RST), .TRI_EN(TRI_EN),
        .DQ_OUT(DQ_OUT), .dbg_state(dbg_state)
    );

    // clock / cycle count
    always #5 CLK_IN = ~CLK_IN;
    int pcount = 0;
    always @(posedge CLK_IN) pcount <= pcount + 1;

    int checks = 0;
    int failures = 0;

    // scoreboard queues, one entry per transaction (bits: one per serial bit)
    int                exp_done_q[$];
    logic [DATA_W-1:0] exp_q[$];
    logic              exp_bit_q[$];
    int                exp_nbits_q[$];
    int                exp_turn_q[$];
    logic [DATA_W-1:0] model_rd = '0;
    logic [DATA_W-1:0] resp_cur = '0;
    int                done_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s", name);
    endtask

    // monitor + sensor model
    logic prev_clk = 1'b1, prev_tri = 1'b0;
    int   rises = 0, falls = 0, turn_at = -1, nbits = 0;

    always @(negedge CLK_IN) begin
        if (!BUSY) begin
            rises = 0; falls = 0; turn_at = -1; nbits = 0;
        end else begin
            if (prev_clk && !CLK_OUT) begin
                if (falls >= CMD_W && falls < CMD_W + DATA_W && !TRI_EN)
                    DQ_IN = resp_cur[falls - CMD_W];
                else
                    DQ_IN = 1'($urandom_range(0, 1));
                falls++;
            end
            if (!prev_clk && CLK_OUT) begin
                if (TRI_EN) begin
                    nbits++;
                    if (exp_bit_q.size() == 0) fail_now("unexpected_serial_bit");
                    else check("serial_bit", 32'(DQ_OUT), 32'(exp_bit_q.pop_front()));
                end
                rises++;
            end
            if (prev_tri && !TRI_EN && RST) turn_at = rises;
            if (!TRI_EN) check("dq_released", 32'(DQ_OUT), 32'd0);
            if (DONE) begin
                done_seen++;
                if (exp_done_q.size() == 0) begin
                    fail_now("unexpected_done");
                end else begin
                    check("done_cycle", 32'(pcount), 32'(exp_done_q.pop_front()));
                    check("rd_data", 32'(RD_DATA), 32'(exp_q.pop_front()));
                    check("bit_count", 32'(nbits), 32'(exp_nbits_q.pop_front()));
                    check("turnaround_after_rises", 32'(turn_at), 32'(exp_turn_q.pop_front()));
                end
            end
        end
        prev_clk = CLK_OUT;
        prev_tri = TRI_EN;
    end

    // driver tasks
    task automatic wait_idle();
        int k;
        for (k = 0; k < 500 && BUSY; k++) @(negedge CLK_IN);
        if (BUSY) fail_now("timeout_wait_idle");
    endtask

    task automatic issue(input logic [CMD_W-1:0] c, input logic [DATA_W-1:0] w,
                         input logic [LEN_W-1:0] l, input logic d, input logic [DATA_W-1:0] r);
        int n;
        logic [DATA_W-1:0] m;
        wait_idle();
        n = (int'(l) > DATA_W) ? DATA_W : int'(l);
        m = '0;
        for (int i = 0; i < n; i++) m[i] = 1'b1;
        for (int i = 0; i < CMD_W; i++) exp_bit_q.push_back(c[i]);
        if (!d) for (int i = 0; i < n; i++) exp_bit_q.push_back(w[i]);
        exp_nbits_q.push_back(CMD_W + (d ? 0 : n));
        exp_turn_q.push_back((d && n > 0) ? CMD_W : -1);
        if (d) model_rd = r & m;
        exp_q.push_back(model_rd);
        exp_done_q.push_back(pcount + CLK_DIV * (2 * (CMD_W + n) + 2) + 1);
        resp_cur = r;
        CMD = c; WR_DATA = w; DATA_LEN = l; DIR = d; START = 1'b1;
        @(negedge CLK_IN);
        START = 1'b0;
    endtask

    // Waits for the DONE pulse while scrambling the request fields.
    task automatic wait_done();
        int start_cnt, k;
        start_cnt = done_seen;
        for (k = 0; k < 1000 && done_seen == start_cnt; k++) begin
            @(negedge CLK_IN);
            CMD = CMD_W'($urandom); WR_DATA = DATA_W'($urandom);
            DATA_LEN = LEN_W'($urandom_range(0, 15)); DIR = 1'($urandom_range(0, 1));
        end
        if (done_seen == start_cnt) fail_now("timeout_wait_done");
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, 32'(BUSY), 32'd0);
        check({tag, "_done"}, 32'(DONE), 32'd0);
        check({tag, "_rst"}, 32'(RST), 32'd0);
        check({tag, "_tri_en"}, 32'(TRI_EN), 32'd0);
        check({tag, "_dq_out"}, 32'(DQ_OUT), 32'd0);
        check({tag, "_clk_out"}, 32'(CLK_OUT), 32'd1);
        check({tag, "_rd_data"}, 32'(RD_DATA), 32'd0);
        check({tag, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
    endtask

    initial begin
        repeat (3) @(negedge CLK_IN);
        check_reset_outputs("reset");
        CLR_N = 1'b1;
        repeat (2) @(negedge CLK_IN);

        issue(READ_TEMP, 9'h1FF, 4'd9, 1'b1, 9'h032);      wait_done();
        issue(WRITE_CONFIG, 9'h0A5, 4'd8, 1'b0, 9'h1FF);   wait_done();
        issue(START_CONVERT, 9'h155, 4'd0, 1'b0, 9'h000);  wait_done();
        issue(READ_CONFIG, 9'h000, 4'd15, 1'b1, 9'h1C3);   wait_done();
        issue(WRITE_CONFIG, 9'h12D, 4'd15, 1'b0, 9'h000);  wait_done();
        issue(READ_TEMP, 9'h000, 4'd0, 1'b1, 9'h0FF);      wait_done();

        for (int t = 0; t < 12; t++) begin
            issue(CMD_W'($urandom), DATA_W'($urandom), LEN_W'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)), DATA_W'($urandom));
            wait_done();
        end

        // START held high through the whole transaction and its DONE cycle
        issue(STOP_CONVERT, 9'h05A, 4'd4, 1'b0, 9'h000);
        for (int k = 0; k < 1000 && BUSY; k++) begin
            START = 1'b1; CMD = CMD_W'($urandom); DIR = 1'($urandom_range(0, 1));
            @(negedge CLK_IN);
        end
        START = 1'b0;
        repeat (60) @(negedge CLK_IN);
        check("busy_after_start_storm", 32'(BUSY), 32'd0);
        check("pending_after_start_storm", 32'(exp_done_q.size()), 32'd0);

        // make RD_DATA nonzero, then abort a read mid data phase
        issue(READ_TEMP, 9'h000, 4'd9, 1'b1, 9'h1A7);      wait_done();
        issue(READ_TEMP, 9'h000, 4'd9, 1'b1, 9'h0F0);
        for (int k = 0; k < 200 && !(BUSY && !TRI_EN && RST); k++) @(negedge CLK_IN);
        check("reached_data_rd", 32'(dbg_state), 32'(ST_DATA_RD));
        repeat (5) @(negedge CLK_IN);
        CLR_N = 1'b0;
        @(negedge CLK_IN);
        check_reset_outputs("abort");
        CLR_N = 1'b1;
        exp_done_q.delete(); exp_q.delete(); exp_bit_q.delete();
        exp_nbits_q.delete(); exp_turn_q.delete();
        model_rd = '0;
        repeat (100) @(negedge CLK_IN);
        check("abort_rd_data", 32'(RD_DATA), 32'd0);
        check("abort_busy", 32'(BUSY), 32'd0);

        issue(WRITE_CONFIG, 9'h0C3, 4'd5, 1'b0, 9'h000);   wait_done();
        wait_idle();
        check("final_queue_drained", 32'(exp_done_q.size() + exp_bit_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog_expired");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/three_wire_master.md
THREE_WIRE_MASTER -- requirements
Module: three_wire_master

Interface
REQ-001 Parameter CLK_DIV, default 4: SCLK half-period in CLK_IN cycles; legal values are 2 or more.
REQ-002 Parameter CMD_W, default 8: command bits per transaction.
REQ-003 Parameter DATA_W, default 9: maximum data bits per transaction.
REQ-004 CLK_IN  in  1  sole clock; all logic on its rising edge.
REQ-005 CLR_N  in  1  synchronous active-low reset.
REQ-006 START  in  1  transaction request; sampled only in IDLE.
REQ-007 CMD  in  CMD_W  command byte, sent LSB first.
REQ-008 WR_DATA  in  DATA_W  write payload, sent LSB first.
REQ-009 DATA_LEN  in  clog2(DATA_W+1)  data-phase bit count; 0 means command only.
REQ-010 DIR  in  1  1 = read data phase, 0 = write data phase.
REQ-011 DQ_IN  in  1  serial data from the sensor.
REQ-012 BUSY  out  1  high in every state except IDLE.
REQ-013 DONE  out  1  one-cycle completion pulse.
REQ-014 RD_DATA  out  DATA_W  last read result, LSB-aligned.
REQ-015 CLK_OUT  out  1  serial clock to the sensor; idles high.
REQ-016 RST  out  1  sensor transfer enable; high only while a transfer is framed.
REQ-017 TRI_EN  out  1  1 = master drives DQ_OUT.
REQ-018 DQ_OUT  out  1  serial data to the sensor.

Function
REQ-019 States are IDLE, SETUP, CMD, DATA_WR, DATA_RD, HOLD and DONE.
REQ-020 Transition rules:
- IDLE to SETUP on START.
- SETUP to CMD after one half-period.
- CMD to DATA_RD or DATA_WR after CMD_W bits; to HOLD directly if the effective length is 0.
- DATA_RD or DATA_WR to HOLD after the data bits.
- HOLD to DONE after one half-period.
- DONE to IDLE after one cycle.
REQ-021 On the START cycle, CMD, WR_DATA, DATA_LEN and DIR are latched; input changes during BUSY have no effect.
REQ-022 START is ignored while BUSY is high, including the DONE cycle.
REQ-023 The half-period tick counter runs only outside IDLE and clears on entering SETUP.
REQ-024 Each bit period starts with CLK_OUT low for CLK_DIV cycles, then high for CLK_DIV cycles.
REQ-025 DQ_OUT changes only on the cycle CLK_OUT falls.
REQ-026 RST is high from SETUP through HOLD and low in DONE and IDLE.
REQ-027 TRI_EN is high in SETUP, CMD and DATA_WR.
REQ-028 TRI_EN goes low on the CLK_OUT falling edge that starts the first read bit and stays low through HOLD.
REQ-029 DQ_OUT is 0 whenever TRI_EN is low.
REQ-030 In DATA_RD, DQ_IN is sampled on the cycle CLK_OUT rises and stored at bit index k, LSB first.
REQ-031 RD_DATA updates only on the DONE cycle of a read transaction.
- Bits at or above the effective length read 0.
- RD_DATA is unchanged after a write transaction.
REQ-032 The effective length is min(DATA_LEN, DATA_W).
REQ-033 DONE is asserted exactly CLK_DIV*(2*(CMD_W+N)+2)+1 cycles after the START cycle, where N is the effective length.

Reset
REQ-034 CLR_N low at a CLK_IN edge forces the following, overriding any transaction in progress:
- state IDLE and all counters 0;
- BUSY, DONE, RST, TRI_EN and DQ_OUT at 0;
- CLK_OUT at 1;
- RD_DATA at 0.
REQ-035 A transaction aborted by reset produces no DONE pulse and no RD_DATA update.

Structure
REQ-036 Package three_wire_pkg holds the following:
- the state enumeration;
- default parameter values;
- sensor command constants READ_TEMP 8'hAA, START_CONVERT 8'hEE, STOP_CONVERT 8'h22, WRITE_CONFIG 8'h0C and READ_CONFIG 8'hAC.
REQ-037 Sub-module three_wire_tick generates the half-period tick from CLK_DIV, with enable and clear inputs.

Verification
REQ-038 Read test, CLK_DIV=2: START with CMD=8'hAA, DIR=1, DATA_LEN=9, with the sensor model returning 9'h032.
- DONE at cycle 73.
- RD_DATA = 9'h032.
- TRI_EN falls after 8 command bits.
REQ-039 Write test: CMD=8'h0C, DIR=0, DATA_LEN=8, WR_DATA=9'h0A5.
- The DQ_OUT sequence at CLK_OUT rises is 0,0,1,1,0,0,0,0 then 1,0,1,0,0,1,0,1.
- RD_DATA is unchanged.
REQ-040 Command-only test: CMD=8'hEE, DATA_LEN=0.
- DONE at cycle CLK_DIV*18+1.
- TRI_EN never falls.
REQ-041 Clamp test: DATA_LEN=15 with DATA_W=9 runs 9 data bits only.
REQ-042 Busy test: START pulsed every cycle during BUSY and in the DONE cycle starts no extra transaction, and the latched CMD is unaffected.
REQ-043 Reset test: CLR_N low mid-DATA_RD.
- On the next cycle all outputs are at their reset values.
- No DONE pulse occurs.
- RD_DATA = 0.
